ccd_line_capture: RTL and testbench
===================================

Name: ccd_line_capture

Overview:
- Downstream consumer of the CCD shift-gate (SH) pulse train.
- Detects each SH pulse, issues ADC conversion triggers at the pixel rate and discards the leading dummy pixels.
- Captures the active pixels into a small FWFT FIFO and presents them as a valid/ready pixel stream with start-of-line and end-of-line markers.
- Sits between the SH timing generator / external ADC and the line-processing datapath.

Parameters:
- ADC_W, 12, ADC sample width in bits.
- PIX_DIV, 8, clk cycles per pixel, i.e. adc_start period (≥2).
- DUMMY_LEAD, 32, conversions discarded after SH falls.
- ACTIVE_PIX, 3648, conversions captured per line.
- FIFO_DEPTH, 16, output FIFO entries (power of 2, ≥2).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- sh_in  in  1  SH pulse from the shift-gate generator; high = transfer.
- adc_start  out  1  one-cycle conversion trigger.
- adc_valid  in  1  one-cycle strobe; adc_data is valid in that cycle.
- adc_data  in  ADC_W  conversion result.
- pix_data  out  ADC_W  pixel at FIFO head.
- pix_valid  out  1  FIFO non-empty.
- pix_ready  in  1  downstream accept; transfer occurs when pix_valid & pix_ready.
- pix_sol  out  1  head pixel is the first active pixel of its line.
- pix_eol  out  1  head pixel is the last active pixel of its line.
- line_done  out  1  one-cycle pulse when the last active pixel is written to the FIFO.
- line_abort  out  1  one-cycle pulse when a line is aborted by an early SH.
- overflow  out  1  sticky; an active pixel was dropped because the FIFO was full.

Behaviour:
- **Reset:**
  - All outputs are 0.
  - FIFO is emptied, all counters are 0, state = IDLE, sh_q = 0.
  - Reset asserted mid-line takes effect on the next clk edge. No line_abort is generated.
- **Edge detection:** sh_in is registered into sh_q.
  - rise = sh_in & ~sh_q.
  - fall = ~sh_in & sh_q.
- **States:**
  - IDLE: on rise, go to SH_HIGH and clear overflow.
  - SH_HIGH: on fall, go to LEAD and zero the trigger counter, capture counter and divider.
  - LEAD:
    - adc_start pulses on the first LEAD cycle, then every PIX_DIV cycles.
    - adc_valid strobes increment the capture counter; their data is discarded.
    - When the capture counter reaches DUMMY_LEAD, go to ACTIVE.
  - ACTIVE:
    - adc_start continues at the same cadence until DUMMY_LEAD+ACTIVE_PIX triggers have been issued; no further triggers after that.
    - Each adc_valid writes adc_data to the FIFO, tagged sol for active index 0 and eol for index ACTIVE_PIX-1.
    - After the write of index ACTIVE_PIX-1, line_done pulses in the same cycle as that write's effect. Go to IDLE.
  - Trigger cadence is continuous across the LEAD→ACTIVE boundary; the divider is not reset there.
- **Early SH:** a rise while in LEAD or ACTIVE:
  - pulses line_abort and goes to SH_HIGH;
  - clears overflow and restarts the line;
  - does not flush pixels already in the FIFO; they drain normally, with no eol delivered for the aborted line.
- **SH edges in other states:** a rise in SH_HIGH is impossible. A fall in IDLE is ignored.
- **adc_valid outside capture:** an adc_valid seen in IDLE or SH_HIGH is ignored.
- **Counter widths:** counters are $clog2(DUMMY_LEAD+ACTIVE_PIX+1) bits; the divider is $clog2(PIX_DIV) bits. None of them wrap within a line.
- **FIFO:**
  - First-word-fall-through. pix_data, pix_sol and pix_eol reflect the head entry whenever pix_valid = 1.
  - pix_valid is 0 when empty, and is asserted the cycle after the first write to an empty FIFO.
  - Simultaneous read and write is allowed at any occupancy, including full. Occupancy is then unchanged and no data is lost.
  - A write while full without a concurrent read drops the pixel and sets overflow. The capture counter still advances, so line_done and state timing are unaffected; the dropped sol/eol marker is lost.
  - Pointers wrap modulo FIFO_DEPTH. Full/empty are distinguished by an extra pointer bit.
  - Outputs are stable while pix_valid & ~pix_ready.

Test Plan:
Bench parameters: PIX_DIV=4, DUMMY_LEAD=2, ACTIVE_PIX=8, FIFO_DEPTH=4; ADC model returns adc_valid 2 cycles after adc_start with data = 0x100 + conversion index.
1. **Nominal line.** One SH pulse (high for 5 cycles), pix_ready=1.
   - Exactly 10 adc_start pulses, spaced 4 cycles apart, the first in the cycle after the SH-fall detection.
   - Stream carries 0x102..0x109, with sol on 0x102 and eol on 0x109.
   - line_done pulses once; overflow=0.
2. **Backpressure.** pix_ready=0 for the whole line, then 1.
   - First 4 active pixels (0x102..0x105) held in the FIFO; the remaining 4 are dropped.
   - overflow=1; line_done still pulses.
   - Drain outputs 0x102..0x105 with sol on 0x102 and no eol.
3. **Full + read.** FIFO full, pix_ready=1 in the same cycle as an adc_valid.
   - No drop; overflow stays 0; order preserved.
4. **Early SH.** SH rise after 5 active pixels.
   - line_abort pulses once; overflow clears.
   - The next line restarts with sol on its first active pixel; no line_done for the aborted line.
5. **Reset mid-ACTIVE.** rst_n low for 1 cycle with 3 entries in the FIFO.
   - Next cycle: pix_valid=0, adc_start=0, state IDLE.
   - A new SH pulse produces a clean nominal line.
6. **Back-to-back lines.** SH pulses 60 cycles apart.
   - Two complete lines, each with a single sol/eol pair and one line_done.

Source files
------------

// File: rtl/ccd_line_capture.sv
// CCD line capture: follows the SH pulse train, paces ADC conversions, skips the
// leading dummy pixels and buffers the active pixels in a small FWFT FIFO.
module ccd_line_capture #(
  parameter int ADC_W      = 12,
  parameter int PIX_DIV    = 8,
  parameter int DUMMY_LEAD = 32,
  parameter int ACTIVE_PIX = 3648,
  parameter int FIFO_DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sh_in,
  output logic             adc_start,
  input  logic             adc_valid,
  input  logic [ADC_W-1:0] adc_data,
  output logic [ADC_W-1:0] pix_data,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic             pix_sol,
  output logic             pix_eol,
  output logic             line_done,
  output logic             line_abort,
  output logic             overflow
);

  localparam int CNT_W = $clog2(DUMMY_LEAD + ACTIVE_PIX + 1);
  localparam int DIV_W = $clog2(PIX_DIV);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int EW    = ADC_W + 2;

  localparam logic [CNT_W-1:0] LEAD_C     = CNT_W'(DUMMY_LEAD);
  localparam logic [CNT_W-1:0] TOTAL_C    = CNT_W'(DUMMY_LEAD + ACTIVE_PIX);
  localparam logic [CNT_W-1:0] LAST_C     = CNT_W'(DUMMY_LEAD + ACTIVE_PIX - 1);
  localparam logic [DIV_W-1:0] DIV_LAST_C = DIV_W'(PIX_DIV - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SH_HIGH = 2'd1,
    LEAD    = 2'd2,
    ACTIVE  = 2'd3
  } state_t;

  state_t           state_r;
  logic             sh_q_r;
  logic [CNT_W-1:0] trig_cnt_r;
  logic [CNT_W-1:0] cap_cnt_r;
  logic [DIV_W-1:0] div_r;
  logic             adc_start_r;
  logic             line_done_r;
  logic             line_abort_r;
  logic             overflow_r;

  logic [EW-1:0]    mem_r [FIFO_DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;

  logic             rise_s;
  logic             fall_s;
  logic             empty_s;
  logic             full_s;
  logic             rd_en_s;
  logic             wr_req_s;
  logic             wr_en_s;
  logic             drop_s;
  logic             wr_sol_s;
  logic             wr_eol_s;
  logic [EW-1:0]    head_s;

  assign rise_s  = sh_in & ~sh_q_r;
  assign fall_s  = ~sh_in & sh_q_r;

  // Extra pointer bit tells a full FIFO from an empty one
  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign rd_en_s = ~empty_s & pix_ready;
  assign wr_en_s = wr_req_s & (~full_s | rd_en_s);
  assign drop_s  = wr_req_s & full_s & ~rd_en_s;

  // Active-pixel write request and its line markers
  always_comb begin
    wr_req_s = 1'b0;
    wr_sol_s = 1'b0;
    wr_eol_s = 1'b0;
    if ((state_r == ACTIVE) && adc_valid && !rise_s) begin
      wr_req_s = 1'b1;
      wr_sol_s = (cap_cnt_r == LEAD_C);
      wr_eol_s = (cap_cnt_r == LAST_C);
    end else begin
      wr_req_s = 1'b0;
      wr_sol_s = 1'b0;
      wr_eol_s = 1'b0;
    end
  end

  // Line sequencing FSM with trigger cadence, capture counting and status pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      sh_q_r       <= 1'b0;
      trig_cnt_r   <= '0;
      cap_cnt_r    <= '0;
      div_r        <= '0;
      adc_start_r  <= 1'b0;
      line_done_r  <= 1'b0;
      line_abort_r <= 1'b0;
      overflow_r   <= 1'b0;
    end else begin
      sh_q_r       <= sh_in;
      adc_start_r  <= 1'b0;
      line_done_r  <= 1'b0;
      line_abort_r <= 1'b0;
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          if (rise_s) begin
            state_r    <= SH_HIGH;
            overflow_r <= 1'b0;
          end
        end
        SH_HIGH: begin
          // The first trigger of the line issues together with entering LEAD
          if (fall_s) begin
            state_r     <= (DUMMY_LEAD == 0) ? ACTIVE : LEAD;
            trig_cnt_r  <= CNT_W'(1);
            cap_cnt_r   <= '0;
            div_r       <= '0;
            adc_start_r <= 1'b1;
          end
        end
        LEAD, ACTIVE: begin
          if (rise_s) begin
            state_r      <= SH_HIGH;
            line_abort_r <= 1'b1;
            overflow_r   <= 1'b0;
          end else begin
            if (div_r == DIV_LAST_C) begin
              div_r <= '0;
              if (trig_cnt_r < TOTAL_C) begin
                trig_cnt_r  <= trig_cnt_r + CNT_W'(1);
                adc_start_r <= 1'b1;
              end
            end else begin
              div_r <= div_r + DIV_W'(1);
            end
            if (adc_valid) begin
              cap_cnt_r <= cap_cnt_r + CNT_W'(1);
              if ((state_r == LEAD) && (cap_cnt_r == LEAD_C - CNT_W'(1))) begin
                state_r <= ACTIVE;
              end
              if ((state_r == ACTIVE) && (cap_cnt_r == LAST_C)) begin
                state_r     <= IDLE;
                line_done_r <= 1'b1;
              end
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Pixel FIFO storage and pointers; a write at full is legal when the head leaves
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      mem_r    <= '{default: '0};
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r[AW-1:0]] <= {wr_sol_s, wr_eol_s, adc_data};
        wr_ptr_r                <= wr_ptr_r + (AW+1)'(1);
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
      end
    end
  end

  assign head_s     = mem_r[rd_ptr_r[AW-1:0]];
  assign pix_data   = head_s[ADC_W-1:0];
  assign pix_eol    = head_s[ADC_W];
  assign pix_sol    = head_s[ADC_W+1];
  assign pix_valid  = ~empty_s;
  assign adc_start  = adc_start_r;
  assign line_done  = line_done_r;
  assign line_abort = line_abort_r;
  assign overflow   = overflow_r;

endmodule

// File: tb/tb_ccd_line_capture.sv
// Scoreboard bench for ccd_line_capture with a fixed-latency ADC model.
module tb_ccd_line_capture;

  localparam int ADC_W      = 12;
  localparam int PIX_DIV    = 4;
  localparam int DUMMY_LEAD = 2;
  localparam int ACTIVE_PIX = 8;
  localparam int FIFO_DEPTH = 4;

  typedef struct packed {
    logic             sol;
    logic             eol;
    logic [ADC_W-1:0] data;
  } pix_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             sh_in;
  logic             adc_start;
  logic             adc_valid;
  logic [ADC_W-1:0] adc_data;
  logic [ADC_W-1:0] pix_data;
  logic             pix_valid;
  logic             pix_ready;
  logic             pix_sol;
  logic             pix_eol;
  logic             line_done;
  logic             line_abort;
  logic             overflow;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   start_cnt = 0;
  int   done_cnt = 0;
  int   abort_cnt = 0;
  pix_t sb_q[$];
  int   start_q[$];

  ccd_line_capture #(
    .ADC_W(ADC_W), .PIX_DIV(PIX_DIV), .DUMMY_LEAD(DUMMY_LEAD),
    .ACTIVE_PIX(ACTIVE_PIX), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sh_in(sh_in), .adc_start(adc_start),
    .adc_valid(adc_valid), .adc_data(adc_data), .pix_data(pix_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_sol(pix_sol),
    .pix_eol(pix_eol), .line_done(line_done), .line_abort(line_abort),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  // Active pixel i of a line (conversion index) carries 0x100 + i
  task automatic push_px(input int first, input int last);
    pix_t p;
    for (int i = first; i <= last; i++) begin
      p.sol  = (i == DUMMY_LEAD);
      p.eol  = (i == DUMMY_LEAD + ACTIVE_PIX - 1);
      p.data = ADC_W'(32'h100 + i);
      sb_q.push_back(p);
    end
  endtask

  task automatic sh_pulse(output int fall_c);
    sh_in = 1'b1;
    repeat (5) step();
    sh_in = 1'b0;
    fall_c = cyc;
  endtask

  // ADC model: result strobes two cycles after each trigger
  initial begin
    logic             d1, d2, sh_prev;
    logic [ADC_W-1:0] dd1, dd2;
    int               conv_idx;
    d1 = 1'b0; d2 = 1'b0; sh_prev = 1'b0;
    dd1 = '0; dd2 = '0; conv_idx = 0;
    adc_valid = 1'b0;
    adc_data  = '0;
    forever begin
      @(posedge clk);
      #2;
      adc_valid = d2;
      adc_data  = dd2;
      d2  = d1;
      dd2 = dd1;
      d1  = adc_start;
      dd1 = ADC_W'(32'h100 + conv_idx);
      if (adc_start) conv_idx++;
      if (sh_in && !sh_prev) conv_idx = 0;
      sh_prev = sh_in;
    end
  end

  // Monitor: event counters, hold stability and scoreboard comparison
  initial begin
    logic held_v;
    pix_t held;
    pix_t exp;
    held_v = 1'b0;
    held   = '0;
    forever begin
      @(negedge clk);
      if (adc_start) begin
        start_cnt++;
        start_q.push_back(cyc);
      end
      if (line_done)  done_cnt++;
      if (line_abort) abort_cnt++;
      if (held_v && rst_n) begin
        check("hold_valid", 32'(pix_valid), 32'd1);
        check("hold_head", 32'({pix_sol, pix_eol, pix_data}), 32'(held));
      end
      if (pix_valid && pix_ready) begin
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_pixel: got 0x%0h sol=%0b eol=%0b, expected no pixel",
                   pix_data, pix_sol, pix_eol);
        end else begin
          exp = sb_q.pop_front();
          check("pixel", 32'({pix_sol, pix_eol, pix_data}), 32'(exp));
        end
      end
      held_v = pix_valid && !pix_ready && rst_n;
      held   = {pix_sol, pix_eol, pix_data};
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f, f2, r, d0, a0, s0;
    rst_n = 1'b0;
    sh_in = 1'b0;
    pix_ready = 1'b0;
    repeat (3) step();
    check("rst_adc_start", 32'(adc_start), 32'd0);
    check("rst_pix_valid", 32'(pix_valid), 32'd0);
    check("rst_pix_data", 32'({pix_sol, pix_eol, pix_data}), 32'd0);
    check("rst_line_done", 32'(line_done), 32'd0);
    check("rst_line_abort", 32'(line_abort), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    step();

    // 1: nominal line
    pix_ready = 1'b1;
    d0 = done_cnt;
    start_q.delete();
    push_px(2, 9);
    sh_pulse(f);
    wait_until(f + 45);
    check("t1_start_count", 32'(start_q.size()), 32'd10);
    check("t1_first_start", 32'(start_q[0]), 32'(f + 1));
    for (int i = 1; i < start_q.size(); i++)
      check("t1_start_gap", 32'(start_q[i] - start_q[i-1]), 32'd4);
    check("t1_line_done", 32'(done_cnt - d0), 32'd1);
    check("t1_overflow", 32'(overflow), 32'd0);
    check("t1_sb_empty", 32'(sb_q.size()), 32'd0);

    // 2: backpressure for the whole line
    pix_ready = 1'b0;
    d0 = done_cnt;
    push_px(2, 5);
    sh_pulse(f);
    wait_until(f + 42);
    check("t2_overflow", 32'(overflow), 32'd1);
    check("t2_line_done", 32'(done_cnt - d0), 32'd1);
    check("t2_pix_valid", 32'(pix_valid), 32'd1);
    check("t2_sb_held", 32'(sb_q.size()), 32'd4);
    pix_ready = 1'b1;
    repeat (8) step();
    check("t2_sb_empty", 32'(sb_q.size()), 32'd0);
    check("t2_drained", 32'(pix_valid), 32'd0);

    // 3: full FIFO read in the same cycle as a write
    pix_ready = 1'b0;
    d0 = done_cnt;
    push_px(2, 9);
    sh_pulse(f);
    check("t3_overflow_cleared", 32'(overflow), 32'd0);
    wait_until(f + 27);
    pix_ready = 1'b1;
    wait_until(f + 45);
    check("t3_overflow", 32'(overflow), 32'd0);
    check("t3_line_done", 32'(done_cnt - d0), 32'd1);
    check("t3_sb_empty", 32'(sb_q.size()), 32'd0);

    // 4: early SH after five active pixels
    pix_ready = 1'b0;
    d0 = done_cnt;
    a0 = abort_cnt;
    push_px(2, 5);
    sh_pulse(f);
    wait_until(f + 29);
    check("t4_overflow_set", 32'(overflow), 32'd1);
    wait_until(f + 30);
    sh_in = 1'b1;
    push_px(2, 9);
    step();
    check("t4_line_abort", 32'(line_abort), 32'd1);
    check("t4_overflow_clr", 32'(overflow), 32'd0);
    pix_ready = 1'b1;
    repeat (4) step();
    sh_in = 1'b0;
    f2 = cyc;
    wait_until(f2 + 45);
    check("t4_abort_count", 32'(abort_cnt - a0), 32'd1);
    check("t4_line_done", 32'(done_cnt - d0), 32'd1);
    check("t4_sb_empty", 32'(sb_q.size()), 32'd0);

    // 5: reset mid-ACTIVE with three pixels buffered
    pix_ready = 1'b0;
    sh_pulse(f);
    wait_until(f + 21);
    check("t5_pre_valid", 32'(pix_valid), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("t5_pix_valid", 32'(pix_valid), 32'd0);
    check("t5_adc_start", 32'(adc_start), 32'd0);
    check("t5_overflow", 32'(overflow), 32'd0);
    s0 = start_cnt;
    wait_until(f + 32);
    check("t5_idle_starts", 32'(start_cnt - s0), 32'd0);
    check("t5_idle_valid", 32'(pix_valid), 32'd0);
    pix_ready = 1'b1;
    d0 = done_cnt;
    push_px(2, 9);
    sh_pulse(f);
    wait_until(f + 45);
    check("t5_line_done", 32'(done_cnt - d0), 32'd1);
    check("t5_sb_empty", 32'(sb_q.size()), 32'd0);

    // 6: back-to-back lines 60 cycles apart
    pix_ready = 1'b1;
    d0 = done_cnt;
    s0 = start_cnt;
    push_px(2, 9);
    push_px(2, 9);
    r = cyc;
    sh_pulse(f);
    wait_until(r + 60);
    sh_pulse(f2);
    wait_until(f2 + 45);
    check("t6_line_done", 32'(done_cnt - d0), 32'd2);
    check("t6_start_count", 32'(start_cnt - s0), 32'd20);
    check("t6_overflow", 32'(overflow), 32'd0);
    check("t6_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
